alu_req_driver: RTL and testbench
=================================

Name: alu_req_driver

Overview:
- Initiator-side controller for the ALU/DIV execution interface.
- Accepts one operation at a time from an upstream valid/ready request channel.
- Drives enable, operator and operands into the ALU and holds them stable until the result is available.
- Acknowledges the result with ex_ready, then presents the buffered result on a downstream valid/ready response channel with a tag, error flag and measured latency.

Parameters:
TAG_W, 4, width of request/response tag
TIMEOUT, 64, maximum ISSUE cycles before abort (must be >= 40 to cover a 32-bit divide)
CNT_W, 7, width of the latency counter (must satisfy 2^CNT_W > TIMEOUT)

Ports:
core_clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid_i  in  1  upstream request valid
req_ready_o  out  1  upstream request ready
req_op_i  in  7  ALU opcode (alu_opcode_e encoding)
req_a_i  in  32  operand A
req_b_i  in  32  operand B
req_tag_i  in  TAG_W  request tag
alu_enable_o  out  1  ALU enable
alu_operator_o  out  7  ALU operator
alu_operand_a_o  out  32  ALU operand A
alu_operand_b_o  out  32  ALU operand B
alu_vector_mode_o  out  2  constant 2'b00 (VEC_MODE32)
alu_ex_ready_o  out  1  result-consumed acknowledge to ALU
alu_result_i  in  32  ALU result
alu_comparison_result_i  in  1  ALU comparison result
alu_ready_i  in  1  ALU result valid
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_result_o  out  32  captured result
rsp_cmp_o  out  1  captured comparison result
rsp_tag_o  out  TAG_W  tag of the completed request
rsp_err_o  out  1  1 = timeout abort
rsp_cycles_o  out  CNT_W  number of ISSUE cycles spent on the operation

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - FSM goes to IDLE.
  - All registered outputs become 0, including alu_operator_o and both operand outputs.
  - req_ready_o=1 and alu_vector_mode_o=2'b00 after reset.
- Reset mid-ISSUE or mid-RESP:
  - The operation is dropped; no response is produced.
  - alu_enable_o is 0 from the next cycle.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready_o=1, alu_enable_o=0, alu_ex_ready_o=0.
  - On req_valid_i=1, latch op, A, B and tag into the ALU-facing registers.
  - Clear the counter and go to ISSUE.
- ISSUE:
  - alu_enable_o=1; operator and operands are held constant for the whole state.
  - req_ready_o=0.
  - The counter increments every ISSUE cycle; its value at capture equals the number of ISSUE cycles, starting at 1.
- Division class: an op is a divide when op[6:2]=5'b01100 (DIVU, DIV, REMU, REM).
- Capture, non-divide ops:
  - The result is captured in the first ISSUE cycle regardless of alu_ready_i (the ALU is combinational for these ops).
  - Total latency: accept edge N, capture edge N+1, rsp_valid_o high from N+1.
- Capture, divide ops:
  - The first ISSUE cycle is the start cycle; alu_ready_i is ignored in it.
  - Capture happens in the first later ISSUE cycle with alu_ready_i=1.
- alu_ex_ready_o is combinational and equals 1 exactly in the capture cycle, 0 otherwise.
- Capture action:
  - Register alu_result_i, alu_comparison_result_i and the counter.
  - Set rsp_err_o=0 and go to RESP.
- Timeout:
  - If the counter reaches TIMEOUT without capture, go to RESP with rsp_err_o=1, rsp_result_o=0, rsp_cmp_o=0 and rsp_cycles_o=TIMEOUT.
  - alu_ex_ready_o stays 0.
  - alu_enable_o drops to 0 the next cycle.
- RESP:
  - rsp_valid_o=1; all rsp_* outputs are stable while rsp_ready_i=0.
  - alu_enable_o=0; req_ready_o=0.
  - When rsp_ready_i=1, go to IDLE.
- No response bypass: sustained throughput is one op per 3 cycles minimum.
- Counter saturates at TIMEOUT and never wraps.
- Simultaneous events: timeout and alu_ready_i=1 in the same cycle means capture wins (err=0).

Test Plan:
- ALU_ADD (7'h18), A=5, B=7, tag=3 -> alu_enable_o high for 1 cycle; rsp_valid_o with result=12, tag=3, err=0, cycles=1.
- ALU_DIV (7'h31), A=32'hFFFFFF9C, B=7; ALU model raises ready 34 cycles after start -> operands stable throughout ISSUE; single alu_ex_ready_o pulse; result=32'hFFFFFFF2, cycles=35.
- ALU_LTS (7'h00), A=32'hFFFFFFFF, B=1, with rsp_ready_i held 0 for 5 cycles -> rsp_cmp_o=1 stable for all 5 cycles; req_ready_o=0 until the handshake, then 1.
- ALU_DIVU (7'h30) with alu_ready_i stuck 0 -> after 64 ISSUE cycles: rsp_err_o=1, result=0, cycles=64; no alu_ex_ready_o pulse; alu_enable_o low next cycle.
- Reset asserted 10 cycles into an ALU_REM -> next cycle all outputs 0 and FSM in IDLE; a following ALU_SUB (7'h19) with A=3, B=5 returns 32'hFFFFFFFE.
- Two back-to-back requests with req_valid_i held high -> second request accepted only after the first response handshake; tags returned in order.

Source files
------------

// File: rtl/alu_req_driver.sv
// alu_req_driver
//   Initiator-side controller for the ALU/DIV execution interface. Accepts
//   one operation at a time from an upstream valid/ready request channel,
//   drives it into the ALU and holds operator/operands stable until the
//   result is available. It then acknowledges the result with
//   alu_ex_ready_o and presents the buffered result downstream together
//   with the tag, a timeout flag and the measured ISSUE latency.
//
// Ports
//   core_clk, rst            clock, synchronous active-high reset
//   req_*                    upstream request channel (valid/ready, op, A, B, tag)
//   alu_enable_o             ALU enable, high for the whole ISSUE state
//   alu_operator_o           latched ALU operator
//   alu_operand_a/b_o        latched ALU operands
//   alu_vector_mode_o        tied to 2'b00 (32-bit scalar mode)
//   alu_ex_ready_o           combinational result acknowledge (capture cycle only)
//   alu_result_i             ALU result
//   alu_comparison_result_i  ALU comparison result
//   alu_ready_i              ALU result valid (only consulted for divides)
//   rsp_*                    downstream response channel (valid/ready, result,
//                            cmp, tag, err = timeout abort, cycles = latency)

module alu_req_driver #(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic             core_clk,
    input  logic             rst,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [6:0]       req_op_i,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,

    output logic             alu_enable_o,
    output logic [6:0]       alu_operator_o,
    output logic [31:0]      alu_operand_a_o,
    output logic [31:0]      alu_operand_b_o,
    output logic [1:0]       alu_vector_mode_o,
    output logic             alu_ex_ready_o,
    input  logic [31:0]      alu_result_i,
    input  logic             alu_comparison_result_i,
    input  logic             alu_ready_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic             rsp_cmp_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,
    output logic [CNT_W-1:0] rsp_cycles_o
);

    // DIVU/DIV/REMU/REM share the upper opcode bits 5'b01100
    localparam logic [4:0]       DIV_CLASS = 5'b01100;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [TAG_W-1:0] tag_q;
    logic             is_div;
    logic             first_cycle;
    logic             capture;
    logic             timeout;

    // Scalar 32-bit mode only
    assign alu_vector_mode_o = 2'b00;

    // Result acknowledge goes straight back to the ALU in the capture cycle
    assign alu_ex_ready_o = capture;

    // Next-state, capture and timeout decisions
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        timeout     = 1'b0;
        is_div      = (alu_operator_o[6:2] == DIV_CLASS);
        // cnt_q is cleared on accept, so zero marks the divider start cycle
        first_cycle = (cnt_q == '0);
        // cnt_inc is the 1-based index of the current ISSUE cycle; saturating
        cnt_inc     = (cnt_q >= TIMEOUT_C) ? TIMEOUT_C : cnt_q + CNT_ONE;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Non-divides are combinational in the ALU: take the result at once
                capture = is_div ? (!first_cycle && alu_ready_i) : 1'b1;
                // Capture wins over a simultaneous timeout
                timeout = !capture && (cnt_inc == TIMEOUT_C);
                if (capture || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge core_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge core_clk) begin
        if (rst) begin
            req_ready_o     <= 1'b1;
            alu_enable_o    <= 1'b0;
            alu_operator_o  <= '0;
            alu_operand_a_o <= '0;
            alu_operand_b_o <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_result_o    <= '0;
            rsp_cmp_o       <= 1'b0;
            rsp_tag_o       <= '0;
            rsp_err_o       <= 1'b0;
            rsp_cycles_o    <= '0;
            cnt_q           <= '0;
            tag_q           <= '0;
        end else begin
            // Handshake/enable flags follow the state being entered
            req_ready_o  <= (state_d == IDLE);
            alu_enable_o <= (state_d == ISSUE);
            rsp_valid_o  <= (state_d == RESP);

            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        alu_operator_o  <= req_op_i;
                        alu_operand_a_o <= req_a_i;
                        alu_operand_b_o <= req_b_i;
                        tag_q           <= req_tag_i;
                        cnt_q           <= '0;
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_inc;
                    if (capture) begin
                        rsp_result_o <= alu_result_i;
                        rsp_cmp_o    <= alu_comparison_result_i;
                        rsp_cycles_o <= cnt_inc;
                        rsp_err_o    <= 1'b0;
                        rsp_tag_o    <= tag_q;
                    end else if (timeout) begin
                        rsp_result_o <= '0;
                        rsp_cmp_o    <= 1'b0;
                        rsp_cycles_o <= TIMEOUT_C;
                        rsp_err_o    <= 1'b1;
                        rsp_tag_o    <= tag_q;
                    end
                end
                RESP: begin
                    // Response registers hold until the downstream handshake
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
module tb_alu_req_driver;

    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CNT_W   = 7;

    localparam logic [6:0] OP_LTS  = 7'h00;
    localparam logic [6:0] OP_ADD  = 7'h18;
    localparam logic [6:0] OP_SUB  = 7'h19;
    localparam logic [6:0] OP_DIVU = 7'h30;
    localparam logic [6:0] OP_DIV  = 7'h31;
    localparam logic [6:0] OP_REMU = 7'h32;
    localparam logic [6:0] OP_REM  = 7'h33;

    logic             core_clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             alu_enable;
    logic [6:0]       alu_operator;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [1:0]       alu_vmode;
    logic             alu_ex_ready;
    logic [31:0]      alu_result;
    logic             alu_cmp;
    logic             alu_rdy;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_cmp;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [CNT_W-1:0] rsp_cycles;

    int tests = 0;
    int fails = 0;

    // ALU environment knobs
    int   ready_at   = 0;   // ISSUE cycle index (1-based) where a divide reports ready; 0 = never
    logic glitch     = 1'b0; // ready level shown in the divider start cycle (must be ignored)
    logic nondiv_rdy = 1'b0; // ready level for combinational ops (must be ignored)
    int   en_cnt     = 0;   // enabled cycles completed so far in the current operation

    alu_req_driver #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .core_clk                (core_clk),
        .rst                     (rst),
        .req_valid_i             (req_valid),
        .req_ready_o             (req_ready),
        .req_op_i                (req_op),
        .req_a_i                 (req_a),
        .req_b_i                 (req_b),
        .req_tag_i               (req_tag),
        .alu_enable_o            (alu_enable),
        .alu_operator_o          (alu_operator),
        .alu_operand_a_o         (alu_a),
        .alu_operand_b_o         (alu_b),
        .alu_vector_mode_o       (alu_vmode),
        .alu_ex_ready_o          (alu_ex_ready),
        .alu_result_i            (alu_result),
        .alu_comparison_result_i (alu_cmp),
        .alu_ready_i             (alu_rdy),
        .rsp_valid_o             (rsp_valid),
        .rsp_ready_i             (rsp_ready),
        .rsp_result_o            (rsp_result),
        .rsp_cmp_o               (rsp_cmp),
        .rsp_tag_o               (rsp_tag),
        .rsp_err_o               (rsp_err),
        .rsp_cycles_o            (rsp_cycles)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    function automatic logic op_is_div(input logic [6:0] op);
        return (op == OP_DIVU) || (op == OP_DIV) || (op == OP_REMU) || (op == OP_REM);
    endfunction

    // Arithmetic the ALU performs for each supported operator
    function automatic logic [31:0] alu_func(input logic [6:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_LTS:  r = {31'h0, $signed(a) < $signed(b)};
            OP_DIVU: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            OP_DIV:  r = (b == 0) ? 32'hFFFFFFFF : 32'($signed(a) / $signed(b));
            OP_REMU: r = (b == 0) ? a : a % b;
            OP_REM:  r = (b == 0) ? a : 32'($signed(a) % $signed(b));
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Behavioural ALU: combinational result, divide ready after a chosen delay
    always_ff @(posedge core_clk) begin
        en_cnt <= alu_enable ? en_cnt + 1 : 0;
    end

    always_comb begin
        alu_result = alu_func(alu_operator, alu_a, alu_b);
        alu_cmp    = $signed(alu_a) < $signed(alu_b);
        alu_rdy    = 1'b0;
        if (alu_enable) begin
            if (op_is_div(alu_operator)) begin
                if (en_cnt == 0) alu_rdy = glitch;
                else             alu_rdy = (ready_at != 0) && (en_cnt + 1 >= ready_at);
            end else begin
                alu_rdy = nondiv_rdy;
            end
        end
    end

    // Expected response from the interface rules
    task automatic model_rsp(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int rdy_at, output logic [31:0] res, output logic cmp,
                             output logic err, output int cyc);
        if (!op_is_div(op)) begin
            res = alu_func(op, a, b); cmp = $signed(a) < $signed(b); err = 1'b0; cyc = 1;
        end else if (rdy_at == 0 || rdy_at > int'(TIMEOUT)) begin
            res = 32'h0; cmp = 1'b0; err = 1'b1; cyc = int'(TIMEOUT);
        end else begin
            res = alu_func(op, a, b); cmp = $signed(a) < $signed(b); err = 1'b0; cyc = rdy_at;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {valid, req_ready, enable, result, cmp, tag, err, cycles}
    function automatic logic [63:0] rsp_bundle(input logic v, input logic rr, input logic en,
                                               input logic [31:0] res, input logic cmp,
                                               input logic [TAG_W-1:0] tag, input logic err,
                                               input logic [CNT_W-1:0] cyc);
        return 64'({v, rr, en, res, cmp, tag, err, cyc});
    endfunction

    // One complete transaction: request, ISSUE observation, stalled response, handshake
    task automatic run_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input int rdy_at, input int stall,
                          input logic [31:0] exp_res, input logic exp_cmp,
                          input logic exp_err, input int exp_cyc);
        int cyc;
        int pulses;
        int held_bad;
        logic [63:0] exp_b;
        @(negedge core_clk);
        ready_at   = rdy_at;
        glitch     = 1'($urandom_range(0, 1));
        nondiv_rdy = 1'($urandom_range(0, 1));
        req_valid  = 1'b1;
        req_op = op; req_a = a; req_b = b; req_tag = tag;
        rsp_ready  = 1'b0;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(negedge core_clk);
        req_valid = 1'b0;
        req_op  = 7'($urandom);
        req_a   = $urandom;
        req_b   = $urandom;
        req_tag = TAG_W'($urandom);
        cyc = 0; pulses = 0; held_bad = 0;
        while (alu_enable && cyc < 200) begin
            if (alu_operator !== op || alu_a !== a || alu_b !== b || req_ready !== 1'b0 ||
                rsp_valid !== 1'b0)
                held_bad++;
            pulses += int'(alu_ex_ready);
            cyc++;
            @(negedge core_clk);
        end
        chk("issue_cycles", 64'(cyc), 64'(exp_cyc));
        chk("issue_hold", 64'(held_bad), 64'd0);
        chk("ex_ready_pulses", 64'(pulses), exp_err ? 64'd0 : 64'd1);
        exp_b = rsp_bundle(1'b1, 1'b0, 1'b0, exp_res, exp_cmp, tag, exp_err, CNT_W'(exp_cyc));
        for (int k = 0; k < stall; k++) begin
            chk("rsp_stall", rsp_bundle(rsp_valid, req_ready, alu_enable, rsp_result, rsp_cmp,
                                        rsp_tag, rsp_err, rsp_cycles), exp_b);
            @(negedge core_clk);
        end
        rsp_ready = 1'b1;
        chk("rsp", rsp_bundle(rsp_valid, req_ready, alu_enable, rsp_result, rsp_cmp,
                              rsp_tag, rsp_err, rsp_cycles), exp_b);
        @(negedge core_clk);
        rsp_ready = 1'b0;
        chk("rsp_done", 64'({rsp_valid, req_ready, alu_ex_ready}), 64'b010);
    endtask

    typedef struct {
        logic [6:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        int               rdy_at;
        int               stall;
        logic [31:0]      exp_res;
        logic             exp_cmp;
        logic             exp_err;
        int               exp_cyc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [6:0]  ops[7];
        logic [6:0]  op;
        logic [31:0] a, b, er;
        logic        ec, ee;
        int          rat, ecyc;

        vecs[0] = '{OP_ADD,  32'd5,          32'd7,          4'd3, 0,  0, 32'd12,         1'b1, 1'b0, 1};
        vecs[1] = '{OP_DIV,  32'hFFFFFF9C,   32'd7,          4'd1, 35, 1, 32'hFFFFFFF2,   1'b1, 1'b0, 35};
        vecs[2] = '{OP_LTS,  32'hFFFFFFFF,   32'd1,          4'd2, 0,  5, 32'd1,          1'b1, 1'b0, 1};
        vecs[3] = '{OP_DIVU, 32'd100,        32'd7,          4'd4, 0,  0, 32'd0,          1'b0, 1'b1, 64};
        vecs[4] = '{OP_REMU, 32'd100,        32'd7,          4'd5, 64, 0, 32'd2,          1'b0, 1'b0, 64};
        vecs[5] = '{OP_REM,  32'd100,        32'd7,          4'd6, 65, 2, 32'd0,          1'b0, 1'b1, 64};
        vecs[6] = '{OP_DIVU, 32'd100,        32'd7,          4'd7, 2,  0, 32'd14,         1'b0, 1'b0, 2};
        vecs[7] = '{OP_SUB,  32'd3,          32'd5,          4'hF, 0,  1, 32'hFFFFFFFE,   1'b1, 1'b0, 1};

        ops = '{OP_LTS, OP_ADD, OP_SUB, OP_DIVU, OP_DIV, OP_REMU, OP_REM};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge core_clk);
        chk("reset_flags", 64'({req_ready, alu_enable, rsp_valid, alu_ex_ready, alu_vmode}),
            64'b1000_00);
        chk("reset_alu_bus", 64'({alu_operator, alu_a, alu_b}), 64'd0);
        chk("reset_rsp_bus", 64'({rsp_result, rsp_cmp, rsp_tag, rsp_err, rsp_cycles}), 64'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].rdy_at, vecs[i].stall,
                   vecs[i].exp_res, vecs[i].exp_cmp, vecs[i].exp_err, vecs[i].exp_cyc);
        end

        // Reset ten cycles into a REM that never completes
        @(negedge core_clk);
        ready_at = 0; glitch = 1'b0;
        req_valid = 1'b1; req_op = OP_REM; req_a = 32'd100; req_b = 32'd7; req_tag = 4'd9;
        @(negedge core_clk);
        req_valid = 1'b0;
        repeat (9) @(negedge core_clk);
        chk("rem_still_issuing", 64'(alu_enable), 64'd1);
        rst = 1'b1;
        @(negedge core_clk);
        rst = 1'b0;
        chk("midreset_flags", 64'({req_ready, alu_enable, rsp_valid, alu_ex_ready}), 64'b1000);
        chk("midreset_alu_bus", 64'({alu_operator, alu_a, alu_b}), 64'd0);
        chk("midreset_rsp_bus", 64'({rsp_result, rsp_cmp, rsp_tag, rsp_err, rsp_cycles}), 64'd0);
        @(negedge core_clk);
        chk("midreset_no_rsp", 64'({rsp_valid, alu_enable}), 64'd0);
        run_op(OP_SUB, 32'd3, 32'd5, 4'd8, 0, 0, 32'hFFFFFFFE, 1'b1, 1'b0, 1);

        // Back-to-back requests with req_valid held high
        @(negedge core_clk);
        nondiv_rdy = 1'b1;
        req_valid = 1'b1; req_op = OP_ADD; req_a = 32'd1; req_b = 32'd2; req_tag = 4'd5;
        rsp_ready = 1'b1;
        @(negedge core_clk);
        chk("b2b_first_issue", 64'({alu_enable, req_ready, alu_a}), 64'({2'b10, 32'd1}));
        req_a = 32'd10; req_b = 32'd20; req_tag = 4'd6;
        @(negedge core_clk);
        chk("b2b_first_rsp", 64'({rsp_valid, req_ready, alu_enable, rsp_tag, rsp_result}),
            64'({3'b100, 4'd5, 32'd3}));
        @(negedge core_clk);
        chk("b2b_gap", 64'({rsp_valid, req_ready, alu_enable}), 64'b010);
        @(negedge core_clk);
        chk("b2b_second_issue", 64'({alu_enable, req_ready, alu_a}), 64'({2'b10, 32'd10}));
        req_valid = 1'b0;
        @(negedge core_clk);
        chk("b2b_second_rsp", 64'({rsp_valid, rsp_tag, rsp_result}), 64'({1'b1, 4'd6, 32'd30}));
        @(negedge core_clk);
        rsp_ready = 1'b0;
        chk("b2b_done", 64'({rsp_valid, req_ready}), 64'b01);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 6)];
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            if (b == 32'h0)        b = 32'd1;
            if (b == 32'hFFFFFFFF) b = 32'd3;
            rat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 70));
            model_rsp(op, a, b, rat, er, ec, ee, ecyc);
            run_op(op, a, b, TAG_W'($urandom), rat, int'($urandom_range(0, 3)), er, ec, ee, ecyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
